// File: rtl/complex_pkg.sv
// complex_pkg -- shared definitions for the complex-arithmetic blocks.
//   cdiv_state_e : FSM encoding of the complex divider
//   cdiv_iter    : number of quotient bits produced by the divider
//   cdiv_quo_w   : signed quotient width (magnitude bits plus sign)
package complex_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } cdiv_state_e;

   // The dividend is |N| (2*din_w bits) with frac_w zero bits appended.
   function automatic int cdiv_iter(input int din_w, input int frac_w);
      return 2 * din_w + frac_w;
   endfunction

   // One extra bit carries the sign, so no quotient can overflow.
   function automatic int cdiv_quo_w(input int din_w, input int frac_w);
      return cdiv_iter(din_w, frac_w) + 1;
   endfunction

endpackage

// File: rtl/complex_div_if.sv
// complex_div_if -- bundle of the complex divider's data/handshake signals.
//   master : operand source / result sink (drives operands, din_valid, dout_ready)
//   slave  : the divider (drives din_ready, quotients, div_zero, dout_valid)
interface complex_div_if
   import complex_pkg::*;
#(
   parameter int DIN_WIDTH  = 16,
   parameter int FRAC_WIDTH = 8
);
   localparam int QUO_WIDTH = cdiv_quo_w(DIN_WIDTH, FRAC_WIDTH);

   logic signed [DIN_WIDTH-1:0] dina_i, dina_q, dinb_i, dinb_q;
   logic                        din_valid, din_ready;
   logic signed [QUO_WIDTH-1:0] quo_i, quo_q;
   logic                        div_zero, dout_valid, dout_ready;

   modport master (
      output dina_i, dina_q, dinb_i, dinb_q, din_valid, dout_ready,
      input  din_ready, quo_i, quo_q, div_zero, dout_valid
   );

   modport slave (
      input  dina_i, dina_q, dinb_i, dinb_q, din_valid, dout_ready,
      output din_ready, quo_i, quo_q, div_zero, dout_valid
   );
endinterface

// File: rtl/serial_udiv.sv
// serial_udiv -- unsigned restoring divider, one quotient bit per cycle, MSB first.
//   clk, rst_n : clock, asynchronous active-low reset
//   start_i    : load dividend and begin N_W iterations
//   dividend_i : unsigned dividend (N_W bits), sampled on start_i
//   divisor_i  : unsigned divisor (D_W bits), must be nonzero and held while busy
//   busy_o     : iterations in progress
//   done_o     : high during the final iteration; quo_o is then the finished quotient
//   quo_o      : quotient as it stands after the current iteration
module serial_udiv #(
   parameter int N_W = 40,
   parameter int D_W = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start_i,
   input  logic [N_W-1:0] dividend_i,
   input  logic [D_W-1:0] divisor_i,
   output logic           busy_o,
   output logic           done_o,
   output logic [N_W-1:0] quo_o
);
   localparam int CNT_W = $clog2(N_W + 1);

   // dvd_q shifts dividend bits out of its MSB while quotient bits enter its LSB.
   logic [N_W-1:0]   dvd_q, dvd_d;
   logic [D_W-1:0]   rem_q, rem_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic [D_W:0]     trial, diff;
   logic             qbit;

   always_comb begin
      trial  = {rem_q, dvd_q[N_W-1]};
      diff   = trial - {1'b0, divisor_i};
      qbit   = (trial >= {1'b0, divisor_i});
      dvd_d  = dvd_q;
      rem_d  = rem_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (start_i) begin
         dvd_d  = dividend_i;
         rem_d  = '0;
         cnt_d  = CNT_W'(N_W);
         busy_d = 1'b1;
      end else if (busy_q) begin
         dvd_d  = {dvd_q[N_W-2:0], qbit};
         // remainder stays below the divisor, so its top trial bit is always 0
         rem_d  = qbit ? diff[D_W-1:0] : trial[D_W-1:0];
         cnt_d  = cnt_q - CNT_W'(1);
         busy_d = (cnt_q != CNT_W'(1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   always_ff @(posedge clk) begin
      dvd_q <= dvd_d;
      rem_q <= rem_d;
   end

   assign busy_o = busy_q;
   assign done_o = busy_q && (cnt_q == CNT_W'(1));
   assign quo_o  = {dvd_q[N_W-2:0], qbit};
endmodule

// File: rtl/signed_mult.sv
// signed_mult -- full-precision signed multiplier (combinational).
//   a_i, b_i : signed operands
//   p_o      : signed product, A_W+B_W bits
module signed_mult #(
   parameter int A_W = 16,
   parameter int B_W = 16
) (
   input  logic signed [A_W-1:0]     a_i,
   input  logic signed [B_W-1:0]     b_i,
   output logic signed [A_W+B_W-1:0] p_o
);
   assign p_o = a_i * b_i;
endmodule

// File: rtl/complex_div.sv
// complex_div -- fixed-point complex division (a_i + j*a_q) / (b_i + j*b_q).
//   clk, rst_n              : clock, asynchronous active-low reset
//   dina_i/dina_q           : signed dividend components
//   dinb_i/dinb_q           : signed divisor components
//   din_valid/din_ready     : input handshake (ready only while idle)
//   quo_i/quo_q             : signed quotients, FRAC_WIDTH fractional bits, truncated toward zero
//   div_zero                : divisor was 0+0j (quotients forced to 0)
//   dout_valid/dout_ready   : output handshake; results held until taken
module complex_div
   import complex_pkg::*;
#(
   parameter  int DIN_WIDTH  = 16,
   parameter  int FRAC_WIDTH = 8,
   localparam int ITER       = cdiv_iter(DIN_WIDTH, FRAC_WIDTH),
   localparam int QUO_WIDTH  = cdiv_quo_w(DIN_WIDTH, FRAC_WIDTH)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic signed [DIN_WIDTH-1:0] dina_i,
   input  logic signed [DIN_WIDTH-1:0] dina_q,
   input  logic signed [DIN_WIDTH-1:0] dinb_i,
   input  logic signed [DIN_WIDTH-1:0] dinb_q,
   input  logic                        din_valid,
   output logic                        din_ready,
   output logic signed [QUO_WIDTH-1:0] quo_i,
   output logic signed [QUO_WIDTH-1:0] quo_q,
   output logic                        div_zero,
   output logic                        dout_valid,
   input  logic                        dout_ready
);
   localparam int PW = 2 * DIN_WIDTH;

   cdiv_state_e                 state_q, state_d;
   logic signed [DIN_WIDTH-1:0] ai_q, aq_q, bi_q, bq_q;
   logic signed [PW-1:0]        p_ii, p_qq, p_qi, p_iq, p_bi2, p_bq2;
   logic signed [PW:0]          n_i, n_q;
   logic [PW-1:0]               den, d_q;
   logic                        neg_i_q, neg_q_q;
   logic                        start, busy_i, busy_q, done_i, done_q;
   logic [ITER-1:0]             res_i, res_q;
   logic signed [QUO_WIDTH-1:0] quo_i_q, quo_i_d, quo_q_q, quo_q_d;
   logic                        div_zero_q, div_zero_d;
   logic                        din_ready_q, dout_valid_q;

   // |v|; fits PW bits because |N| <= 2^(PW-1)
   function automatic logic [PW-1:0] mag_f(input logic signed [PW:0] v);
      logic signed [PW:0] m;
      m = v[PW] ? -v : v;
      return m[PW-1:0];
   endfunction

   function automatic logic signed [QUO_WIDTH-1:0] apply_sign_f(input logic [ITER-1:0] m,
                                                                input logic      neg);
      logic signed [QUO_WIDTH-1:0] s;
      s = signed'({1'b0, m});
      return neg ? -s : s;
   endfunction

   signed_mult #(.A_W(DIN_WIDTH), .B_W(DIN_WIDTH)) u_m_ii  (.a_i(ai_q), .b_i(bi_q), .p_o(p_ii));
   signed_mult #(.A_W(DIN_WIDTH), .B_W(DIN_WIDTH)) u_m_qq  (.a_i(aq_q), .b_i(bq_q), .p_o(p_qq));
   signed_mult #(.A_W(DIN_WIDTH), .B_W(DIN_WIDTH)) u_m_qi  (.a_i(aq_q), .b_i(bi_q), .p_o(p_qi));
   signed_mult #(.A_W(DIN_WIDTH), .B_W(DIN_WIDTH)) u_m_iq  (.a_i(ai_q), .b_i(bq_q), .p_o(p_iq));
   signed_mult #(.A_W(DIN_WIDTH), .B_W(DIN_WIDTH)) u_m_bi2 (.a_i(bi_q), .b_i(bi_q), .p_o(p_bi2));
   signed_mult #(.A_W(DIN_WIDTH), .B_W(DIN_WIDTH)) u_m_bq2 (.a_i(bq_q), .b_i(bq_q), .p_o(p_bq2));

   assign n_i = (PW+1)'(p_ii) + (PW+1)'(p_qq);
   assign n_q = (PW+1)'(p_qi) - (PW+1)'(p_iq);
   // both squares are non-negative and their sum stays below 2^PW
   assign den = p_bi2 + p_bq2;

   // The dividers load |N| << FRAC_WIDTH at the end of CALC; D is registered beside them.
   serial_udiv #(.N_W(ITER), .D_W(PW)) u_div_i (
      .clk(clk), .rst_n(rst_n), .start_i(start),
      .dividend_i({mag_f(n_i), {FRAC_WIDTH{1'b0}}}), .divisor_i(d_q),
      .busy_o(busy_i), .done_o(done_i), .quo_o(res_i)
   );
   serial_udiv #(.N_W(ITER), .D_W(PW)) u_div_q (
      .clk(clk), .rst_n(rst_n), .start_i(start),
      .dividend_i({mag_f(n_q), {FRAC_WIDTH{1'b0}}}), .divisor_i(d_q),
      .busy_o(busy_q), .done_o(done_q), .quo_o(res_q)
   );

   always_comb begin
      state_d    = state_q;
      quo_i_d    = quo_i_q;
      quo_q_d    = quo_q_q;
      div_zero_d = div_zero_q;
      start      = 1'b0;
      unique case (state_q)
         ST_IDLE: if (din_valid && din_ready_q) state_d = ST_CALC;
         ST_CALC: begin
            if (den == '0) begin
               state_d    = ST_DONE;
               div_zero_d = 1'b1;
               quo_i_d    = '0;
               quo_q_d    = '0;
            end else begin
               state_d    = ST_DIV;
               div_zero_d = 1'b0;
               start      = !busy_i && !busy_q;
            end
         end
         ST_DIV: begin
            if (done_i && done_q) begin
               state_d = ST_DONE;
               quo_i_d = apply_sign_f(res_i, neg_i_q);
               quo_q_d = apply_sign_f(res_q, neg_q_q);
            end
         end
         ST_DONE: if (dout_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         din_ready_q  <= 1'b1;
         dout_valid_q <= 1'b0;
         quo_i_q      <= '0;
         quo_q_q      <= '0;
         div_zero_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         // ready/valid are registered copies of the next state so they come straight from flops
         din_ready_q  <= (state_d == ST_IDLE);
         dout_valid_q <= (state_d == ST_DONE);
         quo_i_q      <= quo_i_d;
         quo_q_q      <= quo_q_d;
         div_zero_q   <= div_zero_d;
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == ST_IDLE && din_valid && din_ready_q) begin
         ai_q <= dina_i;
         aq_q <= dina_q;
         bi_q <= dinb_i;
         bq_q <= dinb_q;
      end
      if (state_q == ST_CALC) begin
         neg_i_q <= n_i[PW];
         neg_q_q <= n_q[PW];
         d_q     <= den;
      end
   end

   assign din_ready  = din_ready_q;
   assign dout_valid = dout_valid_q;
   assign quo_i      = quo_i_q;
   assign quo_q      = quo_q_q;
   assign div_zero   = div_zero_q;
endmodule

// File: tb/tb_complex_div.sv
// tb_complex_div -- bench for complex_div: directed vector table, hold/reset
// sequences, and randomized operations checked against an arithmetic model.
module tb_complex_div;
   import complex_pkg::*;

   localparam int DW     = 16;
   localparam int FW     = 8;
   localparam int QW     = cdiv_quo_w(DW, FW);
   localparam int N_RAND = 1000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   complex_div_if #(.DIN_WIDTH(DW), .FRAC_WIDTH(FW)) bus ();

   complex_div #(.DIN_WIDTH(DW), .FRAC_WIDTH(FW)) dut (
      .clk(clk), .rst_n(rst_n),
      .dina_i(bus.dina_i), .dina_q(bus.dina_q),
      .dinb_i(bus.dinb_i), .dinb_q(bus.dinb_q),
      .din_valid(bus.din_valid), .din_ready(bus.din_ready),
      .quo_i(bus.quo_i), .quo_q(bus.quo_q), .div_zero(bus.div_zero),
      .dout_valid(bus.dout_valid), .dout_ready(bus.dout_ready)
   );

   typedef struct {
      int     ai, aq, bi, bq;
      longint qi, qq;
      bit     dz;
      int     lat;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // Complex division straight from the arithmetic definition; longint '/' truncates toward zero.
   function automatic void model(input int ai, aq, bi, bq,
                                 output longint qi, qq, output bit dz);
      longint ni, nq, d;
      ni = longint'(ai) * bi + longint'(aq) * bq;
      nq = longint'(aq) * bi - longint'(ai) * bq;
      d  = longint'(bi) * bi + longint'(bq) * bq;
      dz = (d == 0);
      qi = dz ? 0 : (ni * (longint'(1) << FW)) / d;
      qq = dz ? 0 : (nq * (longint'(1) << FW)) / d;
   endfunction

   function automatic logic signed [DW-1:0] rnd_comp();
      int unsigned sel = $urandom_range(0, 7);
      logic [31:0] r   = $urandom;
      case (sel)
         0:       return {1'b1, {(DW-1){1'b0}}};
         1:       return {1'b0, {(DW-1){1'b1}}};
         2:       return '0;
         3:       return {{(DW-4){r[3]}}, r[3:0]};
         default: return r[DW-1:0];
      endcase
   endfunction

   task automatic drive_noise();
      logic [31:0] r = $urandom;
      bus.din_valid = r[0];
      bus.dina_i = r[DW-1:0];
      bus.dina_q = r[31:32-DW];
      bus.dinb_i = '0;
      bus.dinb_q = r[DW+1:2];
   endtask

   // Present an operand set and return just after the accepting clock edge.
   task automatic send(input int ai, aq, bi, bq);
      int n = 0;
      @(negedge clk);
      bus.dina_i    = ai[DW-1:0];
      bus.dina_q    = aq[DW-1:0];
      bus.dinb_i    = bi[DW-1:0];
      bus.dinb_q    = bq[DW-1:0];
      bus.din_valid = 1'b1;
      while (!bus.din_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.din_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: din_ready stayed %0b, expected 1", bus.din_ready);
      end else begin
         @(posedge clk);
      end
      #1 bus.din_valid = 1'b0;
   endtask

   // Wait for dout_valid (lat = falling edges after the accept edge), stall, then take the result.
   task automatic recv(input int stall, input bit noise,
                       output longint qi, qq, output bit dz, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (noise) drive_noise();
      end while (!bus.dout_valid && lat < 200);
      qi = bus.quo_i;
      qq = bus.quo_q;
      dz = bus.div_zero;
      if (!bus.dout_valid) begin
         n_cmp++;
         n_bad++;
         $display("FAIL recv_timeout: dout_valid stayed %0b, expected 1", bus.dout_valid);
      end
      repeat (stall) begin
         @(negedge clk);
         if (noise) drive_noise();
      end
      bus.din_valid  = 1'b0;
      bus.dout_ready = 1'b1;
      @(posedge clk);
      #1 bus.dout_ready = 1'b0;
   endtask

   initial begin
      vec_t   tbl[8];
      longint qi, qq, eqi, eqq;
      bit     dz, edz;
      int     lat, saw;

      tbl[0] = '{3, 4, 1, 2, 563, -102, 0, 42};
      tbl[1] = '{100, -7, 0, 0, 0, 0, 1, 2};
      tbl[2] = '{-32768, -32768, 1, 0, -8388608, -8388608, 0, 42};
      tbl[3] = '{-7, 0, 2, 0, -896, 0, 0, 42};
      tbl[4] = '{1, 0, 0, 3, 0, -85, 0, 42};
      tbl[5] = '{32767, 32767, -32768, -32768, -255, 0, 0, 42};
      tbl[6] = '{0, 0, 5, 5, 0, 0, 0, 42};
      tbl[7] = '{-1, 0, 0, -1, 0, -256, 0, 42};

      bus.dina_i = '0; bus.dina_q = '0; bus.dinb_i = '0; bus.dinb_q = '0;
      bus.din_valid = 1'b0; bus.dout_ready = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_dout_valid", bus.dout_valid, 0);
      check("rst_quo_i", bus.quo_i, 0);
      check("rst_quo_q", bus.quo_q, 0);
      check("rst_div_zero", bus.div_zero, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_din_ready", bus.din_ready, 1);

      for (int i = 0; i < 8; i++) begin
         send(tbl[i].ai, tbl[i].aq, tbl[i].bi, tbl[i].bq);
         recv(0, 1'b0, qi, qq, dz, lat);
         check($sformatf("vec%0d_quo_i", i), qi, tbl[i].qi);
         check($sformatf("vec%0d_quo_q", i), qq, tbl[i].qq);
         check($sformatf("vec%0d_div_zero", i), dz, tbl[i].dz);
         check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
      end

      // Result held under back-pressure while new requests are offered.
      send(3, 4, 1, 2);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.dout_valid && lat < 200);
      check("hold_latency", lat, 42);
      for (int c = 0; c < 10; c++) begin
         bus.din_valid = 1'b1;
         bus.dina_i = DW'(c + 9);
         bus.dinb_i = '0;
         bus.dinb_q = '0;
         @(negedge clk);
         check("hold_quo_i", bus.quo_i, 563);
         check("hold_quo_q", bus.quo_q, -102);
         check("hold_dout_valid", bus.dout_valid, 1);
         check("hold_din_ready", bus.din_ready, 0);
      end
      bus.din_valid  = 1'b0;
      bus.dout_ready = 1'b1;
      @(posedge clk);
      #1 bus.dout_ready = 1'b0;
      @(negedge clk);
      check("after_hold_din_ready", bus.din_ready, 1);
      check("after_hold_dout_valid", bus.dout_valid, 0);
      saw = 0;
      repeat (50) begin
         @(negedge clk);
         if (bus.dout_valid) saw++;
      end
      check("no_ghost_op", saw, 0);

      // Reset in the 20th DIV cycle discards the operation.
      send(3, 4, 1, 2);
      repeat (20) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_dout_valid", bus.dout_valid, 0);
      check("mid_rst_quo_i", bus.quo_i, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_rst_din_ready", bus.din_ready, 1);
      saw = 0;
      repeat (60) begin
         @(negedge clk);
         if (bus.dout_valid) saw++;
      end
      check("mid_rst_no_output", saw, 0);
      send(3, 4, 1, 2);
      recv(0, 1'b0, qi, qq, dz, lat);
      check("post_rst_quo_i", qi, 563);
      check("post_rst_quo_q", qq, -102);
      check("post_rst_latency", lat, 42);

      // Randomized operations with stalls on both sides.
      for (int k = 0; k < N_RAND; k++) begin
         logic signed [DW-1:0] ai, aq, bi, bq;
         ai = rnd_comp();
         aq = rnd_comp();
         bi = (k % 16 == 5) ? '0 : rnd_comp();
         bq = (k % 16 == 5) ? '0 : rnd_comp();
         model(int'(ai), int'(aq), int'(bi), int'(bq), eqi, eqq, edz);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send(int'(ai), int'(aq), int'(bi), int'(bq));
         recv($urandom_range(0, 3), 1'b1, qi, qq, dz, lat);
         check("rnd_quo_i", qi, eqi);
         check("rnd_quo_q", qq, eqq);
         check("rnd_div_zero", dz, edz);
         check("rnd_latency", lat, edz ? 2 : 42);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
      $fatal(1, "watchdog");
   end
endmodule
